// File: rtl/mem_pkg.sv
// mem_pkg: shared types, constants and lane helpers for dual_port_memory
// Contents:
//   mem_size_t  - access size encoding (none/byte/half/word)
//   mem_state_t - controller state (clear sweep / running)
//   b_stage_t   - port-B response pipeline entry
//   lane_mask   - byte-lane write mask for a size and byte offset
//   extend_load - lane extraction with sign or zero extension
package mem_pkg;

    typedef enum logic [1:0] {SIZE_NONE, SIZE_BYTE, SIZE_HALF, SIZE_WORD} mem_size_t;
    typedef enum logic {MEM_INIT, MEM_RUN} mem_state_t;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        fault;
        logic        sgn;
        mem_size_t   size;
        logic [1:0]  off;
        logic [31:0] word;
    } b_stage_t;

    function automatic logic [3:0] lane_mask(mem_size_t size, logic [1:0] offset);
        lane_mask = size == SIZE_BYTE ? 4'b0001 << offset :
                    size == SIZE_HALF ? 4'b0011 << offset :
                    size == SIZE_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] extend_load(logic [31:0] word, mem_size_t size,
                                                logic [1:0] offset, logic sgn);
        logic [31:0] sh;
        sh = word >> {offset, 3'b000};
        extend_load = size == SIZE_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
                      size == SIZE_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} :
                      size == SIZE_WORD ? word : 32'd0;
    endfunction

endpackage

// File: rtl/dual_port_memory_lane_unit.sv
// mem_lane_unit: store lane alignment and load extraction/extension for port B
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses fault instead of being aligned)
// Ports:
//   req_size_i/req_offset_i/req_wdata_i - incoming request size, byte offset, LSB-justified store data
//   req_offset_o                        - effective byte offset (forced aligned when not trapping)
//   req_mask_o/req_wdata_o              - byte-lane write mask and lane-shifted store data
//   req_fault_o                         - request is misaligned or sizeless (trap build only)
//   ld_word_i/ld_size_i/ld_offset_i/ld_signed_i - word read and its access attributes
//   ld_data_o                           - extracted, extended load data
module mem_lane_unit
    import mem_pkg::*;
(
    input  mem_size_t   req_size_i,
    input  logic [1:0]  req_offset_i,
    input  logic [31:0] req_wdata_i,
    output logic [1:0]  req_offset_o,
    output logic [3:0]  req_mask_o,
    output logic [31:0] req_wdata_o,
    output logic        req_fault_o,
    input  logic [31:0] ld_word_i,
    input  mem_size_t   ld_size_i,
    input  logic [1:0]  ld_offset_i,
    input  logic        ld_signed_i,
    output logic [31:0] ld_data_o
);

`ifdef MEM_MISALIGN_TRAP_EN
    assign req_offset_o = req_offset_i;
    assign req_fault_o  = req_size_i == SIZE_NONE ||
                          (req_size_i == SIZE_HALF && req_offset_i[0]) ||
                          (req_size_i == SIZE_WORD && req_offset_i != 2'b00);
`else
    assign req_offset_o = req_size_i == SIZE_WORD ? 2'b00 :
                          req_size_i == SIZE_HALF ? {req_offset_i[1], 1'b0} : req_offset_i;
    assign req_fault_o  = 1'b0;
`endif

    assign req_mask_o  = req_fault_o ? 4'b0000 : lane_mask(req_size_i, req_offset_o);
    assign req_wdata_o = req_wdata_i << {req_offset_o, 3'b000};
    assign ld_data_o   = extend_load(ld_word_i, ld_size_i, ld_offset_i, ld_signed_i);

endmodule

// File: rtl/dual_port_memory.sv
// dual_port_memory: true dual-port RAM, read-only fetch port A and sized load/store port B
// Optional feature macro: MEM_MISALIGN_TRAP_EN (see mem_lane_unit)
// Ports:
//   clk_i, reset_i                     - clock, synchronous active-high reset
//   a_req_valid_i/a_req_ready_o/a_addr_i - fetch request handshake and byte address
//   a_resp_valid_o/a_rdata_o           - fetch response pulse and word
//   b_req_valid_i/b_req_ready_o/b_addr_i - data request handshake and byte address
//   b_write_i/b_size_i/b_signed_i/b_wdata_i - store flag, size, load sign, store data
//   b_resp_valid_o/b_rdata_o/b_fault_o - data response pulse, load data, access fault
module dual_port_memory
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  a_req_valid_i,
    output logic                  a_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    output logic                  a_resp_valid_o,
    output logic [31:0]           a_rdata_o,
    input  logic                  b_req_valid_i,
    output logic                  b_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic                  b_write_i,
    input  logic [1:0]            b_size_i,
    input  logic                  b_signed_i,
    input  logic [31:0]           b_wdata_i,
    output logic                  b_resp_valid_o,
    output logic [31:0]           b_rdata_o,
    output logic                  b_fault_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;

    logic [31:0]             mem_q [DEPTH];
    mem_state_t              state_q;
    logic [IDX_W-1:0]        clr_q;
    logic                    ready_q;
    logic [READ_LATENCY-1:0] a_vld_q;
    logic [31:0]             a_word_q [READ_LATENCY];
    b_stage_t                b_pipe_q [READ_LATENCY];
    b_stage_t                b_stage_d;
    b_stage_t                b_last;
    logic [IDX_W-1:0]        a_idx, b_idx;
    logic                    a_acc, b_acc, b_we;
    logic [1:0]              b_off;
    logic [3:0]              b_mask;
    logic [31:0]             b_wdata_sh, b_ld_data;
    logic                    b_misalign;
    logic [1:0]              unused_a_low;

    assign unused_a_low  = a_addr_i[1:0];
    assign a_idx         = a_addr_i[ADDR_WIDTH-1:2];
    assign b_idx         = b_addr_i[ADDR_WIDTH-1:2];
    assign a_acc         = a_req_valid_i & ready_q;
    assign b_acc         = b_req_valid_i & ready_q;
    assign b_we          = b_acc & b_write_i & ~reset_i;
    assign a_req_ready_o = ready_q;
    assign b_req_ready_o = ready_q;
    assign b_last        = b_pipe_q[READ_LATENCY-1];

    mem_lane_unit u_lane (
        .req_size_i   (mem_size_t'(b_size_i)),
        .req_offset_i (b_addr_i[1:0]),
        .req_wdata_i  (b_wdata_i),
        .req_offset_o (b_off),
        .req_mask_o   (b_mask),
        .req_wdata_o  (b_wdata_sh),
        .req_fault_o  (b_misalign),
        .ld_word_i    (b_last.word),
        .ld_size_i    (b_last.size),
        .ld_offset_i  (b_last.off),
        .ld_signed_i  (b_last.sgn),
        .ld_data_o    (b_ld_data)
    );

    always_comb begin
        b_stage_d       = '0;
        b_stage_d.valid = b_acc;
        b_stage_d.wr    = b_write_i;
        b_stage_d.fault = b_misalign;
        b_stage_d.sgn   = b_signed_i;
        b_stage_d.size  = mem_size_t'(b_size_i);
        b_stage_d.off   = b_off;
        b_stage_d.word  = mem_q[b_idx];
    end

    // Ready is registered so every output is 0 right after reset, even without a sweep.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= CLEAR_ON_RESET != 0 ? MEM_INIT : MEM_RUN;
            clr_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == MEM_INIT) begin
            clr_q <= clr_q + IDX_W'(1);
            if (&clr_q) begin
                state_q <= MEM_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Reads elsewhere use the pre-edge array, so a same-cycle A read sees old data.
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_q == MEM_INIT) begin
            mem_q[clr_q] <= '0;
        end else if (b_we) begin
            for (int i = 0; i < WORD_BYTES; i++)
                if (b_mask[i]) mem_q[b_idx][8*i +: 8] <= b_wdata_sh[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_vld_q        <= '0;
            for (int i = 0; i < READ_LATENCY; i++) b_pipe_q[i] <= '0;
            a_resp_valid_o <= 1'b0;
            a_rdata_o      <= '0;
            b_resp_valid_o <= 1'b0;
            b_rdata_o      <= '0;
            b_fault_o      <= 1'b0;
        end else begin
            a_vld_q[0]  <= a_acc;
            a_word_q[0] <= mem_q[a_idx];
            b_pipe_q[0] <= b_stage_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                a_vld_q[i]  <= a_vld_q[i-1];
                a_word_q[i] <= a_word_q[i-1];
                b_pipe_q[i] <= b_pipe_q[i-1];
            end
            a_resp_valid_o <= a_vld_q[READ_LATENCY-1];
            a_rdata_o      <= a_vld_q[READ_LATENCY-1] ? a_word_q[READ_LATENCY-1] : '0;
            b_resp_valid_o <= b_last.valid;
            b_rdata_o      <= b_last.valid && !b_last.wr && !b_last.fault ? b_ld_data : '0;
            b_fault_o      <= b_last.valid & b_last.fault;
        end
    end

endmodule

// File: tb/tb_dual_port_memory.sv
// tb_dual_port_memory: scoreboard bench for dual_port_memory (ADDR_WIDTH=10, READ_LATENCY=3)
module tb_dual_port_memory;

    localparam int AW  = 10;
    localparam int LAT = 3;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          due;
    } exp_t;

    logic          clk_i = 1'b0, reset_i = 1'b1;
    logic          a_req_valid_i = 1'b0, b_req_valid_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic          b_write_i = 1'b0, b_signed_i = 1'b0;
    logic [1:0]    b_size_i = 2'b00;
    logic [31:0]   b_wdata_i = '0;
    logic          a_req_ready_o, a_resp_valid_o, b_req_ready_o, b_resp_valid_o, b_fault_o;
    logic [31:0]   a_rdata_o, b_rdata_o;

    int   total = 0, bad = 0, cyc = 0;
    exp_t qa[$], qb[$];

    dual_port_memory #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .a_req_valid_i(a_req_valid_i), .a_req_ready_o(a_req_ready_o), .a_addr_i(a_addr_i),
        .a_resp_valid_o(a_resp_valid_o), .a_rdata_o(a_rdata_o),
        .b_req_valid_i(b_req_valid_i), .b_req_ready_o(b_req_ready_o), .b_addr_i(b_addr_i),
        .b_write_i(b_write_i), .b_size_i(b_size_i), .b_signed_i(b_signed_i), .b_wdata_i(b_wdata_i),
        .b_resp_valid_o(b_resp_valid_o), .b_rdata_o(b_rdata_o), .b_fault_o(b_fault_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Drivers run at the negedge; the request is taken at the next posedge.
    task automatic set_a(input logic [AW-1:0] addr, input logic [31:0] exp);
        a_req_valid_i = 1'b1;
        a_addr_i      = addr;
        qa.push_back('{exp, 1'b0, cyc + 1 + LAT});
    endtask

    task automatic set_b(input logic [AW-1:0] addr, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         input logic [31:0] exp, input logic exp_fault);
        b_req_valid_i = 1'b1;
        b_addr_i      = addr;
        b_write_i     = wr;
        b_size_i      = size;
        b_signed_i    = sgn;
        b_wdata_i     = wdata;
        qb.push_back('{exp, exp_fault, cyc + 1 + LAT});
    endtask

    task automatic tick();
        @(negedge clk_i);
        a_req_valid_i = 1'b0;
        b_req_valid_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (a_resp_valid_o === 1'b1) begin
            exp_t e;
            if (qa.size() == 0) chk("a_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_latency", cyc, e.due);
                chk("a_rdata", a_rdata_o, e.data);
            end
        end
        if (b_resp_valid_o === 1'b1) begin
            exp_t e;
            if (qb.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_latency", cyc, e.due);
                chk("b_rdata", b_rdata_o, e.data);
                chk("b_fault", b_fault_o, e.fault);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n, seen;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_a_ready", a_req_ready_o, 0);
        chk("rst_b_ready", b_req_ready_o, 0);
        chk("rst_a_valid", a_resp_valid_o, 0);
        chk("rst_b_valid", b_resp_valid_o, 0);
        chk("rst_b_fault", b_fault_o, 0);
        chk("rst_b_rdata", b_rdata_o, 0);
        n = 0;
        while (b_req_ready_o !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk_i);
        end
        chk("sweep_cycles", n, 256);
        chk("sweep_a_ready", a_req_ready_o, 1);

        set_a(10'h3FC, 32'h0); tick();
        set_b(10'h010, 1, 2'b01, 0, 32'h000000EF, 0, 0); tick();
        set_b(10'h011, 1, 2'b01, 0, 32'h000000BE, 0, 0); tick();
        set_b(10'h012, 1, 2'b01, 0, 32'h000000AD, 0, 0); tick();
        set_b(10'h013, 1, 2'b01, 0, 32'h000000DE, 0, 0); tick();
        set_a(10'h011, 32'hDEADBEEF); tick();
        set_b(10'h013, 0, 2'b01, 1, 0, 32'hFFFFFFDE, 0); tick();
        set_b(10'h012, 0, 2'b10, 0, 0, 32'h0000DEAD, 0); tick();
        set_b(10'h010, 0, 2'b10, 1, 0, 32'hFFFFBEEF, 0); tick();
        set_b(10'h013, 0, 2'b01, 0, 0, 32'h000000DE, 0); tick();
        set_b(10'h010, 0, 2'b11, 1, 0, 32'hDEADBEEF, 0); tick();
        set_b(10'h011, 0, 2'b10, 0, 0, TRAP ? 32'h0 : 32'h0000BEEF, TRAP); tick();
        set_b(10'h010, 0, 2'b00, 0, 0, 32'h0, TRAP); tick();

        set_b(10'h020, 1, 2'b11, 0, 32'h12345678, 0, 0);
        set_a(10'h020, 32'h0); tick();
        set_a(10'h020, 32'h12345678); tick();
        set_b(10'h022, 1, 2'b11, 0, 32'hCAFEF00D, 0, TRAP); tick();
        set_a(10'h020, TRAP ? 32'h12345678 : 32'hCAFEF00D); tick();

        set_b(10'h3FC, 1, 2'b11, 0, 32'hA5A50001, 0, 0); tick();
        set_a(10'h3FF, 32'hA5A50001); tick();
        set_b(10'h030, 1, 2'b10, 0, 32'hFFFF1234, 0, 0); tick();
        set_b(10'h030, 0, 2'b11, 0, 0, 32'h00001234, 0); tick();
        set_b(10'h032, 1, 2'b10, 0, 32'h0000ABCD, 0, 0); tick();
        set_b(10'h030, 0, 2'b11, 0, 0, 32'hABCD1234, 0); tick();

        repeat (LAT + 3) @(negedge clk_i);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        b_req_valid_i = 1'b1;
        b_addr_i      = 10'h010;
        b_write_i     = 1'b0;
        b_size_i      = 2'b11;
        tick();
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        n = 0;
        seen = 0;
        while (b_req_ready_o !== 1'b1 && n < 1000) begin
            if (b_resp_valid_o !== 1'b0) seen++;
            n++;
            @(negedge clk_i);
        end
        chk("flight_dropped", seen, 0);
        chk("resweep_cycles", n, 256);
        set_a(10'h010, 32'h0);
        set_b(10'h020, 0, 2'b11, 0, 0, 32'h0, 0); tick();
        repeat (LAT + 3) @(negedge clk_i);
        chk("final_drain_a", qa.size(), 0);
        chk("final_drain_b", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_memory.md
Name: dual_port_memory

Overview:
- Parametrised successor to the single-port byte/half/word memory block: a true dual-port RAM with a read-only fetch port (A) and a read/write data port (B).
- Both ports use a valid/ready request handshake and have a configurable read latency.
- Port B supports sized, sign- or zero-extended loads.
- After reset, a built-in clear sweep zeroes the array before requests are accepted.
- Sits between the CPU core (fetch and load/store units) and the array.

Parameters:
- ADDR_WIDTH, 10: byte-address width; the array holds 2**(ADDR_WIDTH-2) 32-bit words.
- READ_LATENCY, 1: clock edges from request acceptance to response; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 runs the zeroing sweep after reset; 0 leaves contents untouched.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- a_req_valid  in  1  fetch request
- a_req_ready  out  1  fetch request accepted
- a_addr  in  ADDR_WIDTH  fetch byte address; addr[1:0] ignored
- a_resp_valid  out  1  fetch data valid (one-cycle pulse)
- a_rdata  out  32  fetched word
- b_req_valid  in  1  data request
- b_req_ready  out  1  data request accepted
- b_addr  in  ADDR_WIDTH  data byte address
- b_write  in  1  1 = store, 0 = load
- b_size  in  2  00 none, 01 byte, 10 half, 11 word
- b_signed  in  1  sign-extend load when 1
- b_wdata  in  32  store data, least-significant-justified
- b_resp_valid  out  1  load data or store acknowledge (one-cycle pulse)
- b_rdata  out  32  extended load data; 0 for stores
- b_fault  out  1  access fault, qualified by b_resp_valid

Behaviour:
- Reset (sync, active-high):
  - Every output goes to 0 at the next edge; all in-flight responses are dropped.
  - The state machine goes to INIT when CLEAR_ON_RESET=1, otherwise to RUN.
  - Reset asserted mid-operation, including mid-sweep, behaves the same way; the sweep restarts at word 0.
- State machine:
  - INIT: one word written to 0 per cycle, counter 0..DEPTH-1; a_req_ready = b_req_ready = 0. After the write of word DEPTH-1, the state moves to RUN.
  - RUN: both ready signals are 1 every cycle; there is no backpressure.
- Acceptance and latency:
  - A request is accepted on an edge where valid & ready.
  - The matching resp_valid is high for exactly the cycle after the READ_LATENCY-th edge following acceptance.
  - The response pipeline is READ_LATENCY deep, so one request per cycle per port is sustained.
  - Responses return in order.
- Port B writes:
  - Applied at the acceptance edge. The byte-lane mask derives from b_size and b_addr[1:0].
  - b_wdata bytes are shifted into the addressed lanes; other lanes are unchanged.
- Port B reads:
  - The addressed lane(s) are extracted.
  - b_signed=1 replicates the top bit of the byte or half into the upper bits; otherwise the upper bits are 0.
  - A word load ignores b_signed.
- b_size=00 is a no-op. The response is still issued with b_rdata=0 and no write.
- Collision: a port-A read and a port-B write to the same word in the same cycle. A returns the old data (read-before-write).
- Ordering: a B read accepted the cycle after a B write to the same word sees the new data.
- Address wrap: bits above ADDR_WIDTH do not exist; the top word is DEPTH-1, with no wrap logic.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with b_addr[0]=1 is misaligned.
  - A word access with b_addr[1:0]!=00 is misaligned.
  - A misaligned access performs no write and returns b_fault=1 with b_rdata=0, at normal latency.
  - b_size=00 also faults.
- Undefined:
  - The low address bits are forced aligned: a half ignores addr[0]; a word ignores addr[1:0].
  - b_fault is tied to 0.

Decomposition:
- Package mem_pkg:
  - enum mem_size_t (SIZE_NONE, SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - enum mem_state_t (MEM_INIT, MEM_RUN)
  - constant WORD_BYTES=4
  - functions lane_mask(size, offset) and extend_load(word, size, offset, signed)
- One sub-module, mem_lane_unit: combinational store alignment (mask plus shifted data) and load extraction/extension, instantiated once for port B.

Test Plan:
- Sweep check: ADDR_WIDTH=10, CLEAR_ON_RESET=1, hold reset 1 cycle. Expect b_req_ready=0 for exactly 256 cycles. Then an A read of 0x3FC returns 0x00000000.
- Byte stores and lane assembly: byte stores 0xEF, 0xBE, 0xAD, 0xDE to 0x10..0x13, then an A read of 0x11. Expect a_rdata=0xDEADBEEF exactly READ_LATENCY cycles after acceptance.
- Load extension, using the data at 0x10 from the previous scenario:
  - Signed byte load of 0x13 gives 0xFFFFFFDE.
  - Unsigned half load of 0x12 gives 0x0000DEAD.
  - Signed half load of 0x10 gives 0xFFFFBEEF.
- Collision: a B word store of 0x12345678 to 0x20 and an A read of 0x20 in the same cycle. A returns the prior value; the A read next cycle returns 0x12345678.
- Misalignment: a word store of 0xCAFEF00D to 0x22.
  - With MEM_MISALIGN_TRAP_EN: b_fault=1 and word 0x20 is unchanged.
  - Without: b_fault=0 and word 0x20 becomes 0xCAFEF00D.
- Reset mid-flight: READ_LATENCY=3, B load accepted, reset asserted the next cycle. Expect no b_resp_valid, b_req_ready=0, and the sweep restarting from word 0.
